// File: rtl/multiplicador.sv
// multiplicador: shift-and-add unsigned multiplier (clk, rst, init, A, B in; producto, busy, done out)
module multiplicador #(
   parameter int N = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           init,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   output logic [2*N-1:0] producto,
   output logic           busy,
   output logic           done
);
   localparam int CW = $clog2(N) + 1;
   typedef enum logic [2:0] {IDLE, CHECK, ADD, SHIFT, DONE} state_t;
   state_t         state_q;
   logic [2*N-1:0] mcand_q, acc_q, producto_q;
   logic [N-1:0]   mplier_q;
   logic [CW-1:0]  cnt_q;
   logic           busy_q, done_q;
   assign producto = producto_q;
   assign busy = busy_q;
   assign done = done_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mcand_q <= '0;
         acc_q <= '0;
         producto_q <= '0;
         mplier_q <= '0;
         cnt_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (init) begin
               mcand_q <= {{N{1'b0}}, A};
               mplier_q <= B;
               acc_q <= '0;
               cnt_q <= '0;
               busy_q <= 1'b1;
               state_q <= CHECK;
            end
            CHECK: state_q <= mplier_q[0] ? ADD : SHIFT;
            ADD: begin
               acc_q <= acc_q + mcand_q;
               state_q <= SHIFT;
            end
            SHIFT: begin
               mcand_q <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(N - 1)) begin
                  producto_q <= acc_q;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  state_q <= CHECK;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
